pc_sequencer: RTL



---
 rtl/pc_sequencer_pkg.sv | 22 ++
 rtl/pc_return_stack.sv | 62 ++++++
 rtl/pc_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-address sequencer: parameter defaults and
// redirect-kind encodings used by the sequencer, its return stack and benches.
package pc_sequencer_pkg;

  localparam int ADDR_WIDTH_DEF   = 32;
  localparam int STEP_DEF         = 4;
  localparam int RESET_VECTOR_DEF = 0;
  localparam int RAS_DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    REDIR_BRANCH = 2'b00,
    REDIR_JUMP   = 2'b01,
    REDIR_CALL   = 2'b10,
    REDIR_RETURN = 2'b11
  } redir_e;

  // Bits that must be zero for an address to be STEP-aligned.
  function automatic logic [63:0] low_mask(input int step);
    return 64'(step - 1);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack: a push past full overwrites the oldest entry,
// a pop on empty leaves everything alone; both events report a one-cycle pulse.
module pc_return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAS_DEPTH  = RAS_DEPTH_DEF,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [RAS_DEPTH-1:0][ADDR_WIDTH-1:0] mem;
  logic [PW-1:0] ptr;      // next slot to write
  logic [PW-1:0] top_idx;
  logic          full;
  logic          empty;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign full    = (count == CW'(RAS_DEPTH));
  assign empty   = (count == '0);

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (push) begin
        ptr <= ptr + PW'(1);
        if (full) overflow <= 1'b1;
        else      count    <= count + CW'(1);
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          ptr   <= top_idx;
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: sequential increment, branch/jump/call/return
// redirects with alignment repair, stall hold and a circular return stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                   ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int                   STEP         = STEP_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF),
  parameter int                   RAS_DEPTH    = RAS_DEPTH_DEF,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redir_valid,
  input  logic [1:0]            redir_type,
  input  logic [ADDR_WIDTH-1:0] redir_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [CW-1:0]         ras_count,
  output logic                  ras_overflow,
  output logic                  ras_underflow,
  output logic                  align_err
);

  localparam logic [ADDR_WIDTH-1:0] LOW  = ADDR_WIDTH'(low_mask(STEP));
  localparam logic [ADDR_WIDTH-1:0] INCR = ADDR_WIDTH'(STEP);

  redir_e                rtype;
  logic [ADDR_WIDTH-1:0] pc_seq;
  logic [ADDR_WIDTH-1:0] raw_addr;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic                  take;
  logic                  ras_push;
  logic                  ras_pop;
  logic                  align_nxt;

  assign rtype  = redir_e'(redir_type);
  assign pc_seq = pc + INCR;
  assign take   = redir_valid && !stall;

  always_comb begin
    pc_nxt    = pc_seq;
    raw_addr  = redir_target;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    align_nxt = 1'b0;
    if (stall) begin
      pc_nxt = pc;
    end else if (take) begin
      case (rtype)
        REDIR_BRANCH: raw_addr = pc + redir_target;
        REDIR_JUMP:   raw_addr = redir_target;
        REDIR_CALL: begin
          raw_addr = redir_target;
          ras_push = 1'b1;
        end
        REDIR_RETURN: ras_pop = 1'b1;
        default:      raw_addr = redir_target;
      endcase
      // Returns pull an address that was aligned when pushed; others get repaired.
      if (rtype == REDIR_RETURN) begin
        pc_nxt = (ras_count != '0) ? ras_top : pc_seq;
      end else begin
        pc_nxt    = raw_addr & ~LOW;
        align_nxt = |(raw_addr & LOW);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      align_err <= 1'b0;
    end else begin
      pc        <= pc_nxt;
      align_err <= align_nxt;
    end
  end

  pc_return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule
